// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_cfg
// Brief   : Runtime-configurable UART transmitter (5-8 data bits, N/E/O
//           parity, 1/2 stop bits) paced by an OVS-times-baud tick.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int OVS = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic [7:0] data_i,
    input  logic [1:0] cfg_dbits_i,
    input  logic [1:0] cfg_parity_i,
    input  logic       cfg_stop2_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int             SW      = $clog2(OVS);
    localparam logic [SW-1:0]  c_S_MAX = SW'(OVS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic [SW-1:0] r_s;
    logic [2:0]    r_n;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic [1:0]    r_dbits;
    logic [1:0]    r_par;
    logic          r_stop2;
    logic          r_parbit;
    logic          r_tx;
    logic          w_tx_next;
    logic          r_done;

    logic          w_accept;
    logic          w_bit_end;
    logic          w_par_en;
    logic [7:0]    w_mask;
    logic          w_in_par;

    assign ready_o   = (r_state == c_ST_IDLE) && !rst_i;
    assign w_accept  = valid_i && ready_o;
    assign w_bit_end = tick_i && (r_s == c_S_MAX);
    assign w_par_en  = (r_par == 2'b01) || (r_par == 2'b10);

    // Parity is fixed at accept time from only the configured data bits.
    assign w_mask   = 8'hFF >> (2'd3 - cfg_dbits_i);
    assign w_in_par = (^(data_i & w_mask)) ^ (cfg_parity_i == 2'b10);

    // State register and datapath
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_ST_IDLE;
            r_s      <= '0;
            r_n      <= '0;
            r_shift  <= '0;
            r_dbits  <= '0;
            r_par    <= '0;
            r_stop2  <= 1'b0;
            r_parbit <= 1'b0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_done  <= (r_state == c_ST_STOP) && (w_state_next == c_ST_IDLE);
            if (w_accept) begin
                r_dbits  <= cfg_dbits_i;
                r_par    <= cfg_parity_i;
                r_stop2  <= cfg_stop2_i;
                r_parbit <= w_in_par;
                r_s      <= '0;
            end else if (r_state != c_ST_IDLE && tick_i) begin
                r_s <= w_bit_end ? '0 : r_s + 1'b1;
            end
            if (w_state_next != r_state) begin
                r_n <= '0;
            end else if (w_bit_end) begin
                r_n <= r_n + 3'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept) w_state_next = c_ST_START;
            c_ST_START:  if (w_bit_end) w_state_next = c_ST_DATA;
            c_ST_DATA:
                if (w_bit_end && r_n == {1'b1, r_dbits})
                    w_state_next = w_par_en ? c_ST_PARITY : c_ST_STOP;
            c_ST_PARITY: if (w_bit_end) w_state_next = c_ST_STOP;
            c_ST_STOP:
                if (w_bit_end && r_n == {2'b00, r_stop2})
                    w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // Output logic: tx is computed from next-state values and registered
    always_comb begin
        w_shift_next = r_shift;
        if (w_accept)
            w_shift_next = data_i;
        else if (r_state == c_ST_DATA && w_bit_end)
            w_shift_next = {1'b0, r_shift[7:1]};

        w_tx_next = 1'b1;
        case (w_state_next)
            c_ST_START:  w_tx_next = 1'b0;
            c_ST_DATA:   w_tx_next = w_shift_next[0];
            c_ST_PARITY: w_tx_next = r_parbit;
            default:     w_tx_next = 1'b1;
        endcase
    end

    assign tx_o   = r_tx;
    assign busy_o = (r_state != c_ST_IDLE);
    assign done_o = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_cfg
// Brief   : Scoreboard bench for uart_tx_cfg; frames decoded from tx_o.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    typedef struct {
        logic [11:0] bits;
        int          n;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       tick_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] data_i = 8'h00;
    logic [1:0] cfg_dbits_i = 2'b11;
    logic [1:0] cfg_parity_i = 2'b00;
    logic       cfg_stop2_i = 1'b0;
    logic       tx_o;
    logic       busy_o;
    logic       done_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   tp      = 1;
    exp_t exp_q[$];

    uart_tx_cfg #(.OVS(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .tick_i       (tick_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .cfg_dbits_i  (cfg_dbits_i),
        .cfg_parity_i (cfg_parity_i),
        .cfg_stop2_i  (cfg_stop2_i),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial forever #5 clk = ~clk;

    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge clk);
            tcnt++;
            tick_i = ((tcnt % tp) == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] d, input logic [1:0] db,
                                   input logic [1:0] pr, input logic st2);
        exp_t e;
        int   nd;
        int   idx;
        logic p;
        e.bits = '0;
        nd  = 5 + int'(db);
        idx = 1;
        p   = 1'b0;
        for (int i = 0; i < nd; i++) begin
            e.bits[idx] = d[i];
            p = p ^ d[i];
            idx++;
        end
        if (pr == 2'b01) begin
            e.bits[idx] = p;
            idx++;
        end else if (pr == 2'b10) begin
            e.bits[idx] = ~p;
            idx++;
        end
        for (int i = 0; i < (st2 ? 2 : 1); i++) begin
            e.bits[idx] = 1'b1;
            idx++;
        end
        e.n = idx;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge of the first START cycle.
    task automatic send(input logic [7:0] d, input logic [1:0] db, input logic [1:0] pr,
                        input logic st2, input bit push, input bit hold);
        int w;
        data_i       = d;
        cfg_dbits_i  = db;
        cfg_parity_i = pr;
        cfg_stop2_i  = st2;
        valid_i      = 1'b1;
        w = 0;
        while (!ready_o && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (!ready_o) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        if (push) exp_q.push_back(model(d, db, pr, st2));
        @(negedge clk);
        if (!hold) valid_i = 1'b0;
    endtask

    // Decodes one frame at mid-bit points; returns at the done_o cycle.
    task automatic watch_frame(input int tpp);
        int          c;
        int          w;
        int          nb;
        int          bp;
        logic [11:0] got;
        bit          bad_ready;
        exp_t        e;
        c = 0; w = 0; nb = 0; got = '0; bad_ready = 1'b0; bp = 16 * tpp;
        while (tx_o !== 1'b0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (tx_o !== 1'b0) begin
            chk("start_timeout", 32'd1, 32'd0);
            return;
        end
        forever begin
            if (done_o) break;
            if (!busy_o) begin
                chk("frame_abort", 32'd1, 32'd0);
                return;
            end
            if ((c % bp) == bp / 2 && nb < 12) begin
                got[nb] = tx_o;
                nb++;
            end
            if (ready_o) bad_ready = 1'b1;
            if (c > 20000) begin
                chk("done_timeout", 32'd1, 32'd0);
                return;
            end
            @(negedge clk);
            c++;
        end
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk("bits", 32'(got), 32'(e.bits));
        chk("nbits", nb, e.n);
        chk("ready_low", 32'(bad_ready), 32'd0);
        if (tpp == 1)
            chk("len", c, bp * e.n);
        else
            chk("len_win", 32'((c >= bp * e.n - tpp + 1) && (c <= bp * e.n)), 32'd1);
    endtask

    initial begin
        int dcount;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        rst_i = 1'b0;
        #1 chk("ready_after_rst", 32'(ready_o), 32'd1);
        @(negedge clk);

        // 8N1 0x55, tick every cycle
        tp = 1;
        send(8'h55, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
        watch_frame(1);
        // 7E1 0x41
        send(8'h41, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0);
        watch_frame(1);
        // 5O2 0xFF then 0xE0 (upper bits masked)
        send(8'hFF, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0);
        watch_frame(1);
        send(8'hE0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0);
        watch_frame(1);
        // reserved parity behaves as none
        send(8'h01, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0);
        watch_frame(1);
        // 6E2 mixed pattern
        send(8'hB6, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
        watch_frame(1);

        // back-to-back with valid held, tick every 4th cycle
        tp = 4;
        send(8'hA5, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1);
        data_i = 8'h3C;
        watch_frame(4);
        exp_q.push_back(model(8'h3C, 2'b11, 2'b00, 1'b0));
        @(negedge clk);
        chk("b2b_start", 32'(tx_o), 32'd0);
        valid_i      = 1'b0;
        data_i       = 8'h00;
        cfg_dbits_i  = 2'b00;
        cfg_parity_i = 2'b10;
        cfg_stop2_i  = 1'b1;
        watch_frame(4);

        // reset mid-DATA
        tp = 1;
        @(negedge clk);
        send(8'h00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("mid_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        #1 chk("midrst_ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        chk("midrst_tx", 32'(tx_o), 32'd1);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        #1 chk("midrst_ready_after", 32'(ready_o), 32'd1);
        dcount = 0;
        repeat (50) begin
            @(negedge clk);
            if (done_o) dcount++;
        end
        chk("no_done_after_rst", dcount, 0);
        send(8'h0F, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
        watch_frame(1);

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter, driven by the shared 16x-oversampling baud tick. Supports 5–8 data bits, none/even/odd parity and 1 or 2 stop bits. It accepts one byte per valid/ready handshake and serialises it LSB-first on tx_o. It is the transmit-side counterpart to the configurable receiver path and sits between the TX FIFO read side and the pad.

Parameters:
OVS, 16, baud ticks per bit period (start, data, parity, each stop bit).

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous, active-high reset
tick_i  input  1  baud tick, 1-cycle pulse at OVS x baud rate
valid_i  input  1  byte available on data_i
ready_o  output  1  block can accept a byte this cycle
data_i  input  8  byte to send; bits above the configured width are ignored
cfg_dbits_i  input  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity_i  input  2  00=none, 01=even, 10=odd, 11=reserved (treated as none)
cfg_stop2_i  input  1  0=1 stop bit, 1=2 stop bits
tx_o  output  1  serial line, idle high
busy_o  output  1  frame in progress (state != IDLE)
done_o  output  1  1-cycle pulse at the end of the last stop bit

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset: state=IDLE; tx_o=1, busy_o=0, done_o=0, tick counter=0, bit counter=0. ready_o is 0 while rst_i is high.
- ready_o = (state==IDLE) && !rst_i. It is combinational from state and is 0 for the whole frame.
- Accept: valid_i && ready_o at a rising edge.
  - Latch data_i, cfg_dbits_i, cfg_parity_i and cfg_stop2_i into shadow registers.
  - Config changes mid-frame have no effect.
- Accept: enter START, clear tick counter s. tx_o=0 from the next cycle.
- A tick_i in the accept cycle is not counted. tick_i is ignored in IDLE.
- valid_i while ready_o=0 is ignored. No data is lost upstream, because the FIFO only pops on accept.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counting: s is $clog2(OVS) bits (4 for the default OVS=16) and increments on each tick_i.
- Bit-period end: tick_i && s==OVS-1 ends a bit period; s then wraps to 0.
- START: tx_o=0. At bit end go to DATA with n=0.
- DATA: tx_o = shift register bit 0; the register shifts right at each bit end. n counts 0..D-1, where D = 5 + cfg_dbits.
  - At bit end with n==D-1, go to PARITY if parity is enabled, otherwise STOP.
- PARITY: tx_o = XOR of the D data bits for even, its inverse for odd. Only the latched data bits below D are included. One bit period, then STOP.
- STOP: tx_o=1 for OVS ticks (1 stop bit) or 2*OVS ticks (2 stop bits). n counts stop bits.
- Frame end: at the end of the last stop bit, pulse done_o for exactly that cycle and go to IDLE. ready_o=1 the following cycle.
- Minimum gap: back-to-back frames have 1 clk of idle high between the stop bit and the next start bit. This is less than one tick period, so the line is effectively continuous.
- Frame length in ticks: OVS*(1+D+P+S), where P is 1 if parity is enabled and S is the stop-bit count.
- Registered output: tx_o is registered, so there are no glitches.
- Reset mid-frame: the next cycle is IDLE with tx_o=1. No done_o pulse is produced and the latched byte is discarded.
- Reserved cfg_parity_i=11 behaves exactly as none.

Test Plan:
1. tick_i every cycle; 8N1; send 0x55.
   - tx_o after accept, each level held 16 cycles: 0,1,0,1,0,1,0,1,0,1.
   - done_o pulses at cycle 160 after entry to START.
   - ready_o is low throughout the frame.
2. 7E1; send 0x41 (bits 1,0,0,0,0,0,1).
   - Data bits appear LSB-first, then parity bit 0, then 1 stop bit.
   - Frame is 10 bit periods = 160 ticks.
3. 5O2; send 0xFF.
   - Five 1 data bits, then parity 0, then two stop bits of 1 (32 ticks).
   - Total 144 ticks.
   - Repeat with 0xE0: data bits are 0,0,0,0,0 and parity is 1 (upper bits masked).
4. tick_i every 4th cycle; 8N1; hold valid_i high with 0xA5 then 0x3C.
   - Two frames, each 640 clk.
   - Second start bit follows done_o by 1 clk.
   - Change cfg inputs mid-frame: the frame is unaffected.
5. Assert rst_i for 1 cycle mid-DATA of a 0x00 frame.
   - Next cycle: tx_o=1, busy_o=0, no done_o pulse.
   - ready_o=1 after rst_i drops.
   - A new 0x0F frame then transmits correctly.
6. cfg_parity_i=11, 8 data bits, 0x01.
   - Frame is identical to 8N1: 10 bit periods, no parity bit.
